// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N-to-1 multiplexer.
// Holds the mode encoding and the one-hot decoder used for the channel strobe.
package mux_pkg;

  typedef enum logic {
    MODO_MANUAL = 1'b0,
    MODO_AUTO   = 1'b1
  } modo_t;

  // Widest channel count the block supports; onehot_f returns this many bits.
  localparam int MAX_CANALES = 16;

  // One-hot decode of a channel index; out-of-range indices decode to zero.
  function automatic logic [MAX_CANALES-1:0] onehot_f(input int index, input int canales);
    logic [MAX_CANALES-1:0] r;
    r = '0;
    if (index >= 0 && index < canales) r = MAX_CANALES'(1) << index;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_nto1_tick_gen.sv
// Auto-scan prescaler: counts 0..divisor-1 while enabled and pulses tick on
// the terminal count. clr restarts the count and suppresses that cycle's tick.
module tick_gen #(
  parameter int divisor = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (divisor > 1) ? $clog2(divisor) : 1;
  localparam logic [CW-1:0] LAST = CW'(divisor - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Prescaler count: clear wins over counting, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Scanning N-to-1 multiplexer with registered data and one-hot channel strobe,
// intended to drive a multiplexed display. Manual mode follows sel; auto mode
// steps through channels at the prescaler rate.
// Optional feature: define MUX_SCAN_SKIP_EN to add the skip input, which makes
// auto scan jump over masked channels and blanks the strobe on them.
module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int ancho   = 4,
  parameter int canales = 4,
  parameter int divisor = 50000,
  localparam int IW     = $clog2(canales)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [canales*ancho-1:0]   D,
  input  logic [IW-1:0]              sel,
  input  logic                       modo,
  input  logic                       en,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [canales-1:0]         skip,
`endif
  output logic [ancho-1:0]           Y,
  output logic [canales-1:0]         ch,
  output logic [IW-1:0]              idx
);

  logic [ancho-1:0]       dv [canales];
  logic [canales-1:0]     skip_m;
  modo_t                  modo_q;
  logic                   primed;
  logic                   modo_chg;
  logic                   tick;
  logic [IW-1:0]          idx_step;
  logic [IW-1:0]          idx_load;
  logic [canales-1:0]     ch_nxt;
  logic [MAX_CANALES-1:0] oh;

  for (genvar k = 0; k < canales; k++) begin : g_slice
    assign dv[k] = D[k*ancho +: ancho];
  end

`ifdef MUX_SCAN_SKIP_EN
  assign skip_m = skip;
`else
  assign skip_m = '0;
`endif

  // Next channel in wrap order that is not masked; holds if none qualifies.
  function automatic logic [IW-1:0] next_idx_f(input logic [IW-1:0] cur,
                                               input logic [canales-1:0] sk);
    logic [IW-1:0]      r;
    logic [canales-1:0] t;
    int                 c;
    r = cur;
    for (int k = canales - 1; k >= 1; k--) begin
      c = (int'(cur) + k) % canales;
      t = sk >> c;
      if (!t[0]) r = IW'(c);
    end
    return r;
  endfunction

  // A mode change is only meaningful once a previous mode has been sampled
  // after reset, so the first enabled cycle never clears the prescaler.
  assign modo_chg = primed && (modo_t'(modo) != modo_q);

  tick_gen #(.divisor(divisor)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en && (modo_t'(modo) == MODO_AUTO)),
    .clr  (modo_chg),
    .tick (tick)
  );

  // Next-index candidates and strobe decode for the current index.
  always_comb begin
    idx_step = next_idx_f(idx, skip_m);
    idx_load = (32'(sel) >= canales) ? '0 : sel;
    oh       = onehot_f(int'(idx), canales);
    ch_nxt   = skip_m[idx] ? '0 : oh[canales-1:0];
  end

  // Previous-mode tracker for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modo_q <= MODO_MANUAL;
      primed <= 1'b0;
    end else begin
      modo_q <= modo_t'(modo);
      primed <= 1'b1;
    end
  end

  // Channel index: a mode change keeps the current channel; otherwise auto
  // advances on tick and manual follows sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (en && !modo_chg) begin
      if (modo_t'(modo) == MODO_AUTO) begin
        if (tick) idx <= idx_step;
      end else begin
        idx <= idx_load;
      end
    end
  end

  // Output stage: data and strobe registered together from idx; disable holds
  // data and blanks the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y  <= '0;
      ch <= '0;
    end else if (en) begin
      Y  <= dv[idx];
      ch <= ch_nxt;
    end else begin
      ch <= '0;
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1 (ancho=4, canales=4, divisor=3).
// Builds with or without MUX_SCAN_SKIP_EN.
module tb_mux_scan_nto1;

  localparam int AN = 4;
  localparam int CN = 4;
  localparam int DV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] D   = 16'h0;
  logic [1:0]  sel = 2'd0;
  logic        modo = 1'b0;
  logic        en   = 1'b0;
  logic [3:0]  skip = 4'b0;
  logic [3:0]  Y;
  logic [3:0]  ch;
  logic [1:0]  idx;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  int       m_idx, m_cnt, m_primed;
  bit       m_prev;
  bit [3:0] m_y, m_ch;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.ancho(AN), .canales(CN), .divisor(DV)) dut (
    .clk  (clk),
    .rst  (rst),
    .D    (D),
    .sel  (sel),
    .modo (modo),
    .en   (en),
`ifdef MUX_SCAN_SKIP_EN
    .skip (skip),
`endif
    .Y    (Y),
    .ch   (ch),
    .idx  (idx)
  );

  typedef struct {
    bit       modo;
    bit       en;
    bit [1:0] sel;
    bit [3:0] y;
    bit [3:0] ch;
    bit [1:0] idx;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit skipped(input int c);
`ifdef MUX_SCAN_SKIP_EN
    return skip[c];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int next_ch(input int cur);
    for (int k = 1; k < CN; k++)
      if (!skipped((cur + k) % CN)) return (cur + k) % CN;
    return cur;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_primed = 0; m_prev = 0; m_y = 0; m_ch = 0;
  endtask

  // One clock edge of the behaviour, from the inputs present at that edge.
  task automatic model_step();
    bit chg, tk;
    chg = (m_primed != 0) && (modo != m_prev);
    tk  = en && modo && !chg && (m_cnt == DV - 1);
    if (en) begin
      m_y  = 4'((D >> (AN * m_idx)) & 16'hF);
      m_ch = skipped(m_idx) ? 4'b0 : 4'(1 << m_idx);
    end else begin
      m_ch = 4'b0;
    end
    if (chg) m_cnt = 0;
    else if (en && modo) m_cnt = (m_cnt + 1) % DV;
    if (en && !chg) begin
      if (modo) begin
        if (tk) m_idx = next_ch(m_idx);
      end else begin
        m_idx = (int'(sel) < CN) ? int'(sel) : 0;
      end
    end
    m_prev = modo;
    m_primed = 1;
  endtask

  task automatic cyc(input bit vs_model);
    @(posedge clk);
    model_step();
    #1;
    if (vs_model) begin
      chk("Y_vs_model",   32'(Y),   32'(m_y));
      chk("ch_vs_model",  32'(ch),  32'(m_ch));
      chk("idx_vs_model", 32'(idx), 32'(m_idx));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_Y", 32'(Y), 0);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_idx", 32'(idx), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1, 1, 0, 4'hA, 4'b0001, 0};
    tbl[1]  = '{1, 1, 0, 4'hA, 4'b0001, 0};
    tbl[2]  = '{1, 1, 0, 4'hA, 4'b0001, 1};
    tbl[3]  = '{1, 1, 0, 4'hB, 4'b0010, 1};
    tbl[4]  = '{1, 1, 0, 4'hB, 4'b0010, 1};
    tbl[5]  = '{1, 1, 0, 4'hB, 4'b0010, 2};
    tbl[6]  = '{1, 1, 0, 4'hC, 4'b0100, 2};
    tbl[7]  = '{1, 1, 0, 4'hC, 4'b0100, 2};
    tbl[8]  = '{1, 1, 0, 4'hC, 4'b0100, 3};
    tbl[9]  = '{1, 1, 0, 4'hD, 4'b1000, 3};
    tbl[10] = '{1, 1, 0, 4'hD, 4'b1000, 3};
    tbl[11] = '{1, 1, 0, 4'hD, 4'b1000, 0};
    tbl[12] = '{1, 1, 0, 4'hA, 4'b0001, 0};
    tbl[13] = '{0, 1, 2, 4'hA, 4'b0001, 0};
    tbl[14] = '{0, 1, 2, 4'hA, 4'b0001, 2};
    tbl[15] = '{0, 1, 3, 4'hC, 4'b0100, 3};
    tbl[16] = '{0, 1, 3, 4'hD, 4'b1000, 3};

    // Auto scan then manual selection, table-driven.
    D = 16'hDCBA; modo = 1; en = 1; sel = 0; skip = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      modo = tbl[i].modo; en = tbl[i].en; sel = tbl[i].sel;
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("tbl%0d_Y", i),   32'(Y),   32'(tbl[i].y));
      chk($sformatf("tbl%0d_ch", i),  32'(ch),  32'(tbl[i].ch));
      chk($sformatf("tbl%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
    end

    // Freeze with en=0 at idx=1, prescaler count 1.
    modo = 1; en = 1; sel = 0;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1);
    chk("frz_pre_idx", 32'(idx), 1);
    chk("frz_pre_Y", 32'(Y), 32'hB);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("frz_idx", 32'(idx), 1);
      chk("frz_ch", 32'(ch), 0);
      chk("frz_Y", 32'(Y), 32'hB);
    end
    en = 1;
    cyc(1);
    chk("resume_Y", 32'(Y), 32'hB);
    chk("resume_ch", 32'(ch), 32'b0010);
    chk("resume_idx", 32'(idx), 1);
    cyc(1);
    chk("resume_adv_idx", 32'(idx), 2);

    // Asynchronous reset between edges at idx=3.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1);
    chk("arst_pre_idx", 32'(idx), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_Y", 32'(Y), 0);
    chk("arst_ch", 32'(ch), 0);
    chk("arst_idx", 32'(idx), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("arst_restart_Y", 32'(Y), 32'hA);
    chk("arst_restart_ch", 32'(ch), 32'b0001);

    // Mode toggled 1->0->1 on the tick cycle.
    do_reset();
    cyc(1); cyc(1);
    modo = 0; cyc(1);
    chk("tog_noadv0", 32'(idx), 0);
    modo = 1; cyc(1);
    chk("tog_noadv1", 32'(idx), 0);
    cyc(1); cyc(1);
    chk("tog_wait", 32'(idx), 0);
    cyc(1);
    chk("tog_adv", 32'(idx), 1);

`ifdef MUX_SCAN_SKIP_EN
    // Skipped channels in auto scan, then everything masked.
    skip = 4'b0110;
    do_reset();
    cyc(1);
    chk("skip_ch0", 32'(ch), 32'b0001);
    cyc(1); cyc(1); cyc(1);
    chk("skip_ch3", 32'(ch), 32'b1000);
    cyc(1); cyc(1); cyc(1);
    chk("skip_ch0b", 32'(ch), 32'b0001);
    skip = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("allskip_ch", 32'(ch), 0);
      chk("allskip_idx", 32'(idx), 0);
    end
    skip = 4'b0100;
    modo = 0; sel = 2;
    cyc(1); cyc(1); cyc(1);
    chk("man_skip_ch", 32'(ch), 0);
    chk("man_skip_Y", 32'(Y), 32'(D[11:8]));
    skip = 0;
`endif

    // Randomized run against the reference.
    modo = 1; en = 1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      D   = 16'($urandom);
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) modo = ~modo;
`ifdef MUX_SCAN_SKIP_EN
      if ($urandom_range(0, 31) == 0) skip = 4'($urandom);
`endif
      if (i == 200) do_reset();
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_nto1.md
MUX_SCAN_NTO1 -- requirements
Module: mux_scan_nto1

Interface
REQ-001 The block SHALL have parameter ancho, default 4, data width per channel.
REQ-002 The block SHALL have parameter canales, default 4, channel count, legal range 2..16.
REQ-003 The block SHALL have parameter divisor, default 50000, clk cycles per auto-scan step, legal minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 The block SHALL have port D, input, canales*ancho bits, packed channel data, channel k at bits [k*ancho +: ancho].
REQ-007 The block SHALL have port sel, input, $clog2(canales) bits, channel select used in manual mode.
REQ-008 The block SHALL have port modo, input, 1 bit: 0 = manual, 1 = auto-scan.
REQ-009 The block SHALL have port en, input, 1 bit, run enable.
REQ-010 The block SHALL have port Y, output, ancho bits, registered selected data.
REQ-011 The block SHALL have port ch, output, canales bits, registered one-hot active-channel strobe (display anode drive).
REQ-012 The block SHALL have port idx, output, $clog2(canales) bits, current channel index register.

Function
REQ-013 The prescaler SHALL count 0..divisor-1 while en=1 and modo=1, wrap to 0, and assert tick for one cycle at count divisor-1.
REQ-014 In auto mode, idx SHALL advance by one on each tick, wrapping canales-1 -> 0.
REQ-015 In manual mode, idx SHALL load sel every cycle when en=1; sel >= canales SHALL load 0.
REQ-016 Y SHALL be registered from D slice selected by idx, and ch from onehot(idx): one cycle latency after idx, with Y and ch always aligned.
REQ-017 en=0 SHALL freeze idx and prescaler, hold Y, and drive ch to all zeros on the next edge.
REQ-018 A change of modo SHALL clear the prescaler to 0, and idx SHALL be kept: auto scan resumes from the current channel.
REQ-019 If tick and a modo change occur in the same cycle, the modo change SHALL win: no advance, prescaler cleared.
REQ-020 With divisor=1, tick SHALL be asserted every enabled auto cycle.

Reset
REQ-021 While rst=1: idx=0, prescaler=0, Y=0, ch=0, regardless of clk.
REQ-022 Reset asserted mid-scan SHALL abort the scan immediately; the first valid Y/ch SHALL appear one edge after rst deasserts with en=1.

Configuration
REQ-023 Macro MUX_SCAN_SKIP_EN defined: the block SHALL add an input skip, canales bits, and the auto-scan step SHALL advance to the next channel in wrap order whose skip bit is 0.
REQ-024 With MUX_SCAN_SKIP_EN, if all skip bits are 1, idx SHALL hold and ch SHALL be 0. In manual mode a selected skipped channel SHALL give ch=0 with Y still updated.
REQ-025 Macro undefined: no skip port, and every channel SHALL be visited in sequence.

Structure
REQ-026 Package mux_pkg SHALL hold typedef enum logic modo_t {MODO_MANUAL=0, MODO_AUTO=1} and function onehot_f(index, canales).
REQ-027 The prescaler SHALL be a separate sub-module tick_gen with parameter divisor and ports clk, rst, en, clr, tick.

Verification
REQ-028 ancho=4, canales=4, divisor=3, D=16'hDCBA, modo=1, en=1 after reset -> Y sequence A,B,C,D,A, each held 3 cycles; ch = 0001,0010,0100,1000,0001.
REQ-029 modo=0, sel=2 then sel=3 on consecutive cycles -> Y=C then D, one cycle after idx; ch=0100 then 1000.
REQ-030 Auto scan at idx=1 with prescaler count 1: en=0 for 5 cycles -> idx stays 1, ch=0000, Y holds B; en=1 -> B returns, advance after 1 more cycle.
REQ-031 rst pulse asserted between clock edges during auto scan at idx=3 -> Y=0, ch=0, idx=0 immediately; scan restarts at A.
REQ-032 MUX_SCAN_SKIP_EN, skip=4'b0110, auto -> ch sequence 0001,1000,0001. skip=4'b1111 -> ch=0000, idx frozen.
REQ-033 modo toggled 1->0->1 on the tick cycle -> no advance, prescaler restarts, next advance exactly 3 cycles later.
